// File: rtl/seg_scan_decoder.sv
// Decodes a multiplexed 4-digit seven-segment display observed on its segment/select wires.
// Optional SEG_DEC_BLANK_EN: an all-dark digit decodes to 4'hA as a valid blank.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  seg_led,
    input  logic [3:0]  seg_block,
    output logic [15:0] digits,
    output logic [3:0]  dots,
    output logic        frame_valid,
    output logic        frame_err
);

    typedef enum logic {IDLE, COLLECT} state_t;

    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [7:0]  led_s1, led_s2, led_q;
    logic [3:0]  blk_s1, blk_s2, blk_q;
    logic [15:0] stab_cnt;
    logic        accept;

    // The bus is asynchronous to us; led_q/blk_q is the sample whose dwell stab_cnt measures.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            led_s1   <= 8'h00;
            led_s2   <= 8'h00;
            led_q    <= 8'h00;
            blk_s1   <= 4'hF;
            blk_s2   <= 4'hF;
            blk_q    <= 4'hF;
            stab_cnt <= 16'd0;
        end else begin
            led_s1 <= seg_led;
            led_s2 <= led_s1;
            led_q  <= led_s2;
            blk_s1 <= seg_block;
            blk_s2 <= blk_s1;
            blk_q  <= blk_s2;
            if ({blk_s2, led_s2} != {blk_q, led_q})
                stab_cnt <= 16'd0;
            else if (stab_cnt != 16'hFFFF)
                stab_cnt <= stab_cnt + 16'd1;
        end
    end

    assign accept = (stab_cnt == SETTLE_LAST);

    logic [3:0] seg_code;
    logic       seg_ok;

    always_comb begin
        seg_code = 4'hF;
        seg_ok   = 1'b0;
        case (led_q[6:0])
            7'h3F: begin seg_code = 4'h0; seg_ok = 1'b1; end
            7'h06: begin seg_code = 4'h1; seg_ok = 1'b1; end
            7'h5B: begin seg_code = 4'h2; seg_ok = 1'b1; end
            7'h4F: begin seg_code = 4'h3; seg_ok = 1'b1; end
            7'h66: begin seg_code = 4'h4; seg_ok = 1'b1; end
            7'h6D: begin seg_code = 4'h5; seg_ok = 1'b1; end
            7'h7D: begin seg_code = 4'h6; seg_ok = 1'b1; end
            7'h07: begin seg_code = 4'h7; seg_ok = 1'b1; end
            7'h7F: begin seg_code = 4'h8; seg_ok = 1'b1; end
            7'h6F: begin seg_code = 4'h9; seg_ok = 1'b1; end
`ifdef SEG_DEC_BLANK_EN
            7'h00: begin seg_code = 4'hA; seg_ok = 1'b1; end
`endif
            default: ;
        endcase
    end

    logic [1:0] blk_idx;
    logic       blk_digit;
    logic       blk_bad;

    // All selects dark is the inter-digit gap; any multi-select pattern is a fault.
    always_comb begin
        blk_idx   = 2'd0;
        blk_digit = 1'b0;
        blk_bad   = 1'b0;
        case (blk_q)
            4'b1110: begin blk_idx = 2'd0; blk_digit = 1'b1; end
            4'b1101: begin blk_idx = 2'd1; blk_digit = 1'b1; end
            4'b1011: begin blk_idx = 2'd2; blk_digit = 1'b1; end
            4'b0111: begin blk_idx = 2'd3; blk_digit = 1'b1; end
            4'b1111: ;
            default: blk_bad = 1'b1;
        endcase
    end

    state_t      state;
    logic [1:0]  next_idx;
    logic [15:0] shadow_digits;
    logic [3:0]  shadow_dots;
    logic [3:0]  shadow_bad;
    logic        commit;
    logic [31:0] to_cnt;

    // Frame assembly; the shadow is published one cycle after digit3 is stored.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= IDLE;
            next_idx      <= 2'd0;
            shadow_digits <= 16'h0000;
            shadow_dots   <= 4'h0;
            shadow_bad    <= 4'h0;
            commit        <= 1'b0;
            to_cnt        <= 32'd0;
            digits        <= 16'h0000;
            dots          <= 4'h0;
            frame_valid   <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            commit      <= 1'b0;
            if (commit) begin
                digits      <= shadow_digits;
                dots        <= shadow_dots;
                frame_valid <= 1'b1;
                frame_err   <= |shadow_bad;
            end
            if (accept && blk_bad) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end else if (accept && blk_digit &&
                         (blk_idx == 2'd0 || (state == COLLECT && blk_idx == next_idx))) begin
                shadow_digits[{blk_idx, 2'b00} +: 4] <= seg_code;
                shadow_dots[blk_idx]                 <= led_q[7];
                shadow_bad[blk_idx]                  <= ~seg_ok;
                to_cnt                               <= 32'd0;
                if (blk_idx == 2'd3) begin
                    state  <= IDLE;
                    commit <= 1'b1;
                end else begin
                    state    <= COLLECT;
                    next_idx <= blk_idx + 2'd1;
                end
            end else if (accept && blk_digit && state == COLLECT) begin
                frame_err <= 1'b1;
                state     <= IDLE;
            end else if (state == COLLECT) begin
                if (to_cnt == TIMEOUT_LAST) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                end else begin
                    to_cnt <= to_cnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench for seg_scan_decoder: a segment-dwell reference model predicts every
// frame_valid/frame_err pulse (cycle and content); a monitor pops and compares them.
module tb_seg_scan_decoder;

    localparam int S = 16;
    localparam int T = 2000;

    typedef struct {
        logic [3:0] blk;
        logic [7:0] led;
        int         hold;
    } seg_t;

    typedef struct {
        int          cyc;
        logic        valid;
        logic        err;
        logic [15:0] digits;
        logic [3:0]  dots;
    } evt_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  seg_led = 8'h00;
    logic [3:0]  seg_block = 4'hF;
    logic [15:0] digits;
    logic [3:0]  dots;
    logic        frame_valid;
    logic        frame_err;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    seg_t        seg_q[$];
    evt_t        exp_q[$];
    logic [15:0] model_digits = 16'h0000;
    logic [3:0]  model_dots = 4'h0;
    logic [7:0]  pats [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .seg_led(seg_led),
        .seg_block(seg_block),
        .digits(digits),
        .dots(dots),
        .frame_valid(frame_valid),
        .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void decode(input logic [7:0] led, output logic [3:0] code, output bit ok);
        code = 4'hF;
        ok   = 0;
        for (int k = 0; k < 10; k++)
            if (led[6:0] == pats[k][6:0]) begin
                code = 4'(k);
                ok   = 1;
            end
`ifdef SEG_DEC_BLANK_EN
        if (led[6:0] == 7'h00) begin
            code = 4'hA;
            ok   = 1;
        end
`endif
    endfunction

    function automatic void emit(input int c, input bit v, input bit e, input int horizon);
        evt_t ev;
        ev.cyc    = c;
        ev.valid  = v;
        ev.err    = e;
        ev.digits = model_digits;
        ev.dots   = model_dots;
        if (c < horizon) exp_q.push_back(ev);
    endfunction

    // Reference model: merge the driven segments into dwells, then walk the accepted dwells.
    task automatic model_phase(input int n0, input int horizon);
        int          rs[$], re[$];
        logic [3:0]  rb[$];
        logic [7:0]  rl[$];
        logic [3:0]  pb = 4'hF;
        logic [7:0]  pl = 8'h00;
        int          t = n0, cur = n0 - 100000, want = 0, last = 0;
        logic [3:0]  sh_code [4];
        bit          sh_dp [4], sh_bad [4];
        foreach (seg_q[i]) begin
            if (seg_q[i].blk != pb || seg_q[i].led != pl) begin
                rs.push_back(cur); re.push_back(t); rb.push_back(pb); rl.push_back(pl);
                pb = seg_q[i].blk; pl = seg_q[i].led; cur = t;
            end
            t += seg_q[i].hold;
        end
        rs.push_back(cur); re.push_back(t); rb.push_back(pb); rl.push_back(pl);
        foreach (rs[i]) begin
            int a = rs[i] + S + 3;
            int idx = -1;
            logic [3:0] code;
            bit ok;
            if (re[i] - rs[i] < S || rb[i] == 4'hF) continue;
            if (want != 0 && a > last + T) begin
                emit(last + T, 0, 1, horizon);
                want = 0;
            end
            for (int k = 0; k < 4; k++) begin
                logic [3:0] m = 4'b0001 << k;
                if (rb[i] == ~m) idx = k;
            end
            decode(rl[i], code, ok);
            if (idx < 0) begin
                emit(a, 0, 1, horizon);
                want = 0;
            end else if (idx == 0 || (want != 0 && idx == want)) begin
                sh_code[idx] = code; sh_dp[idx] = rl[i][7]; sh_bad[idx] = !ok;
                last = a;
                want = idx + 1;
                if (idx == 3) begin
                    for (int k = 0; k < 4; k++) begin
                        model_digits[4*k +: 4] = sh_code[k];
                        model_dots[k] = sh_dp[k];
                    end
                    emit(a + 1, 1, sh_bad[0] | sh_bad[1] | sh_bad[2] | sh_bad[3], horizon);
                    want = 0;
                end
            end else if (want != 0) begin
                emit(a, 0, 1, horizon);
                want = 0;
            end
        end
        if (want != 0) emit(last + T, 0, 1, horizon);
    endtask

    task automatic add_seg(input logic [3:0] b, input logic [7:0] l, input int h);
        seg_t s;
        s.blk = b; s.led = l; s.hold = h;
        seg_q.push_back(s);
    endtask

    task automatic apply_stimulus(input seg_t s);
        seg_block = s.blk;
        seg_led   = s.led;
        repeat (s.hold) @(posedge sys_clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge sys_clk); #1;
        sys_rst = 1'b1;
        seg_block = 4'hF;
        seg_led = 8'h00;
        exp_q.delete();
        model_digits = 16'h0000;
        model_dots = 4'h0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_output("reset_digits", 32'(digits), 32'h0);
        check_output("reset_dots", 32'(dots), 32'h0);
        check_output("reset_pulses", {30'd0, frame_valid, frame_err}, 32'h0);
        sys_rst = 1'b0;
    endtask

    // Drives the queued segments (plus an idle tail unless reset follows) against the model.
    task automatic run_phase(input bit reset_follows);
        int n0 = cyc, total = 0;
        if (!reset_follows) add_seg(4'hF, 8'h00, T + 60);
        foreach (seg_q[i]) total += seg_q[i].hold;
        model_phase(n0, n0 + total);
        foreach (seg_q[i]) apply_stimulus(seg_q[i]);
        seg_q.delete();
        if (!reset_follows) begin
            @(negedge sys_clk);
            check_output("pending_events", 32'(exp_q.size()), 32'h0);
            check_output("held_digits", 32'(digits), 32'(model_digits));
            check_output("held_dots", 32'(dots), 32'(model_dots));
            exp_q.delete();
        end
    endtask

    task automatic gen_random(input int n);
        int p = 0;
        logic [3:0] pb = 4'hF, b, m;
        logic [7:0] pl = 8'h00, l;
        int r, h;
        repeat (n) begin
            r = $urandom_range(0, 99);
            if (r < 75) begin
                m = 4'b0001 << p; b = ~m; p = (p + 1) % 4;
            end else if (r < 85) begin
                b = 4'hF;
            end else if (r < 92) begin
                m = 4'b0001 << $urandom_range(0, 3); b = ~m;
            end else begin
                b = 4'($urandom_range(0, 15));
            end
            r = $urandom_range(0, 99);
            if (r < 80) l = pats[$urandom_range(0, 9)] | (8'($urandom_range(0, 1)) << 7);
            else if (r < 90) l = 8'($urandom);
            else l = 8'($urandom_range(0, 1)) << 7;
            h = ($urandom_range(0, 99) < 85) ? $urandom_range(S, S + 30) : $urandom_range(2, S - 1);
            if (b == pb && l == pl) l[7] = ~l[7];
            add_seg(b, l, h);
            pb = b; pl = l;
        end
    endtask

    always @(negedge sys_clk) begin : monitor
        evt_t e;
        if (!sys_rst && (frame_valid || frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pulse: actual valid=%0b err=%0b at cycle %0d, required no pulse",
                         frame_valid, frame_err, cyc);
            end else begin
                e = exp_q.pop_front();
                check_output("pulse_cycle", 32'(cyc), 32'(e.cyc));
                check_output("pulse_valid", {31'd0, frame_valid}, {31'd0, e.valid});
                check_output("pulse_err", {31'd0, frame_err}, {31'd0, e.err});
                if (e.valid) begin
                    check_output("frame_digits", 32'(digits), 32'(e.digits));
                    check_output("frame_dots", 32'(dots), 32'(e.dots));
                end
            end
        end
    end

    initial begin
        reset_dut();
        add_seg(4'b1110, 8'h3F, 40); add_seg(4'b1101, 8'h86, 40);
        add_seg(4'b1011, 8'h5B, 40); add_seg(4'b0111, 8'h4F, 40);
        run_phase(0);
        check_output("basic_digits", 32'(digits), 32'h3210);
        check_output("basic_dots", 32'(dots), 32'h2);

        reset_dut();
        add_seg(4'b1110, 8'h3F, 40); add_seg(4'b1101, 8'h86, 10);
        add_seg(4'b1011, 8'h5B, 40); add_seg(4'b0111, 8'h4F, 40);
        run_phase(0);
        check_output("short_dwell_digits", 32'(digits), 32'h0000);

        reset_dut();
        add_seg(4'b1110, 8'h3F, 40); add_seg(4'b1101, 8'h86, 40);
        add_seg(4'b1011, 8'h55, 40); add_seg(4'b0111, 8'h4F, 40);
        run_phase(0);
        check_output("bad_glyph_digits", 32'(digits), 32'h3F10);

        reset_dut();
        add_seg(4'b1110, 8'h3F, 40); add_seg(4'b1101, 8'h06, 40);
        add_seg(4'b1111, 8'h00, T + 300);
        run_phase(0);
        check_output("timeout_digits", 32'(digits), 32'h0000);

        reset_dut();
        add_seg(4'b1110, 8'h3F, 40); add_seg(4'b1101, 8'h06, 40); add_seg(4'b1011, 8'h5B, 40);
        run_phase(1);
        reset_dut();
        add_seg(4'b1110, 8'h3F, 40); add_seg(4'b1101, 8'h3F, 40);
        add_seg(4'b1011, 8'h3F, 40); add_seg(4'b0111, 8'h3F, 40);
        run_phase(0);
        check_output("after_reset_digits", 32'(digits), 32'h0000);

        reset_dut();
        add_seg(4'b1110, 8'h3F, 40); add_seg(4'b1101, 8'h06, 40);
        add_seg(4'b1011, 8'h5B, 40); add_seg(4'b0111, 8'h00, 40);
        run_phase(0);
`ifdef SEG_DEC_BLANK_EN
        check_output("blank_digits", 32'(digits), 32'hA210);
`else
        check_output("blank_digits", 32'(digits), 32'hF210);
`endif

        for (int ph = 0; ph < 4; ph++) begin
            reset_dut();
            gen_random(40);
            run_phase(0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
